signed_seq_divider: RTL and testbench

//   Iterative signed 8-bit divider (quotient + remainder) for the CPU ALU: the inverse of the

---
 rtl/cpu_alu_pkg.sv | 18 +
 rtl/signed_seq_divider_if.sv | 26 ++
 rtl/div_trial_sub.sv | 22 ++
 rtl/signed_seq_divider.sv | 132 +++++++++++++
 tb/tb_signed_seq_divider.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the CPU ALU iterative signed divider.
//   DEF_WIDTH : default operand/result width
//   SMIN      : most negative value for DEF_WIDTH (1 << (DEF_WIDTH-1))
//   CNT_W     : iteration counter width for DEF_WIDTH
//   div_state_e : divider FSM state encoding
package cpu_alu_pkg;

  localparam int DEF_WIDTH = 8;
  localparam logic [DEF_WIDTH-1:0] SMIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};
  localparam int CNT_W = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } div_state_e;

endpackage

// File: rtl/signed_seq_divider_if.sv
// Start/busy/done handshake bundle between the ALU control FSM and the divider.
//   master : drives start, dividend, divisor; observes status and results
//   slave  : the divider itself
interface signed_seq_divider_if #(
  parameter int WIDTH = 8
);
  logic                    start;
  logic signed [WIDTH-1:0] dividend;
  logic signed [WIDTH-1:0] divisor;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] quotient;
  logic signed [WIDTH-1:0] remainder;
  logic                    div_by_zero;
  logic                    overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div_trial_sub.sv
// Combinational (WIDTH+1)-bit trial subtractor for restoring division.
//   p      : partial remainder {R, next dividend bit}
//   d      : divisor magnitude (zero-extended to WIDTH+1 bits internally)
//   diff   : p - d, computed as p + ~{0,d} + 1
//   borrow : 1 when p < d, i.e. the caller must restore p
module div_trial_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   diff,
  output logic             borrow
);

  logic [WIDTH+1:0] sum;

  // Carry out of the two's-complement add is the inverted borrow.
  assign sum    = {1'b0, p} + {1'b0, ~{1'b0, d}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign diff   = sum[WIDTH:0];
  assign borrow = ~sum[WIDTH+1];

endmodule

// File: rtl/signed_seq_divider.sv
// Iterative signed divider, one restoring-division quotient bit per clock.
// Results truncate toward zero; remainder takes the sign of the dividend.
// Fixed latency: done pulses WIDTH+1 clocks after the edge accepting start.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start, bus.dividend, bus.divisor : request, sampled only in IDLE
//   bus.busy   : high while an operation is in flight
//   bus.done   : one-cycle result-valid pulse
//   bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow : held results
module signed_seq_divider
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  signed_seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // |MIN| wraps to MIN, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg(x) : x;
  endfunction

  div_state_e state, state_nxt;
  logic [CW-1:0] count;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_mag, dvd_raw;
  logic             sign_q, sign_r, zero_q, ovf_q;

  logic [WIDTH:0] trial_p, trial_diff, rem_next;
  logic           trial_borrow;
  logic           accept;
  logic           unused_rem_msb;

  // ---- trial subtract ----
  assign trial_p = {rem_q, quo_q[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .p      (trial_p),
    .d      (dvs_mag),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  assign rem_next = trial_borrow ? trial_p : trial_diff;
  // The new partial remainder is always below the divisor, so its MSB is zero.
  assign unused_rem_msb = rem_next[WIDTH];

  // ---- FSM next state ----
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CALC;
          accept    = 1'b1;
        end
      end
      CALC:    if (count == CW'(1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control and result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      count           <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus.done <= 1'b0;
      if (accept) begin
        count    <= CW'(WIDTH);
        bus.busy <= 1'b1;
      end else if (state == CALC) begin
        count <= count - CW'(1);
      end else if (state == FIXUP) begin
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        if (zero_q) begin
          bus.quotient    <= '1;
          bus.remainder   <= dvd_raw;
          bus.div_by_zero <= 1'b1;
          bus.overflow    <= 1'b0;
        end else if (ovf_q) begin
          bus.quotient    <= MIN_VAL;
          bus.remainder   <= '0;
          bus.div_by_zero <= 1'b0;
          bus.overflow    <= 1'b1;
        end else begin
          bus.quotient    <= sign_q ? neg(quo_q) : quo_q;
          bus.remainder   <= sign_r ? neg(rem_q) : rem_q;
          bus.div_by_zero <= 1'b0;
          bus.overflow    <= 1'b0;
        end
      end
    end
  end

  // ---- iteration datapath ----
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q   <= '0;
      quo_q   <= abs_mag(bus.dividend);
      dvs_mag <= abs_mag(bus.divisor);
      dvd_raw <= bus.dividend;
      sign_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      sign_r  <= bus.dividend[WIDTH-1];
      zero_q  <= (bus.divisor == '0);
      ovf_q   <= ($unsigned(bus.dividend) == MIN_VAL) && ($unsigned(bus.divisor) == {WIDTH{1'b1}});
    end else if (state == CALC) begin
      rem_q <= rem_next[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], ~trial_borrow};
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed self-checking bench for signed_seq_divider (WIDTH = 8).
module tb_signed_seq_divider;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  signed_seq_divider_if #(.WIDTH(8)) bus ();

  signed_seq_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check latency, results and flags.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edz, input logic eov, input bit chk_pulse);
    int lat;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd1);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat[7:0], 8'd9);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dz"}, {7'd0, bus.div_by_zero}, {7'd0, edz});
    chk({tag, "_ovf"}, {7'd0, bus.overflow}, {7'd0, eov});
    if (chk_pulse) begin
      chk({tag, "_busy_at_done"}, {7'd0, bus.busy}, 8'd0);
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, {7'd0, bus.done}, 8'd0);
    end
  endtask

  initial begin
    int dones;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_done", {7'd0, bus.done}, 8'd0);
    chk("rst_q", bus.quotient, 8'h00);
    chk("rst_r", bus.remainder, 8'h00);
    chk("rst_flags", {6'd0, bus.div_by_zero, bus.overflow}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("p100_7",   8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 1'b1);
    do_op("m100_7",   8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 1'b1);
    do_op("p7_m100",  8'd7,   8'h9C,  8'h00, 8'h07, 1'b0, 1'b0, 1'b1);
    do_op("min_m1",   8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 1'b1);
    do_op("min_p1",   8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
    do_op("p5_0",     8'd5,   8'h00,  8'hFF, 8'h05, 1'b1, 1'b0, 1'b1);
    do_op("min_0",    8'h80,  8'h00,  8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);
    do_op("p127_min", 8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0, 1'b1);
    do_op("m7_2",     8'hF9,  8'd2,   8'hFD, 8'hFF, 1'b0, 1'b0, 1'b1);

    // Start pulses during a running operation must be ignored.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    @(posedge clk);
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3 || k == 9) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (k == 5) begin
        chk("ign_hold_q", bus.quotient, 8'hFD);
        chk("ign_hold_r", bus.remainder, 8'hFF);
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        chk("ign_done_cycle", k[7:0], 8'd9);
        chk("ign_q", bus.quotient, 8'h0E);
        chk("ign_r", bus.remainder, 8'h02);
      end
    end
    chk("ign_done_count", dones[7:0], 8'd1);

    // Back-to-back: second start on the first IDLE cycle after done.
    do_op("b2b_a", 8'd50,  8'd5, 8'h0A, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op("b2b_b", 8'hCE,  8'd5, 8'hF6, 8'h00, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of CALC.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd99;
    bus.divisor  = 8'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("mid_rst_q", bus.quotient, 8'h00);
    chk("mid_rst_r", bus.remainder, 8'h00);
    chk("mid_rst_flags", {6'd0, bus.div_by_zero, bus.overflow}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("mid_rst_no_done", dones[7:0], 8'd0);
    do_op("after_rst", 8'd99, 8'd4, 8'h18, 8'h03, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
